fpu_apu_allocator: RTL and testbench
====================================

Name: fpu_apu_allocator

Overview:
- Centralised scheduler that shares NB_APUS shared FPUs among NB_CORES requesting cores.
- Each cycle it assigns each requesting core a distinct, least-loaded, non-saturated APU.
- Drives the per-core routing address consumed by each core's request address decoder, with the optimised-allocation option enabled.
- Tracks per-APU outstanding operations from request/grant and result-valid events, and exports a per-APU busy status vector.

Parameters:
- NB_CORES, 8, number of requesting cores (>=1).
- NB_APUS, 4, number of shared FPU units (>=1).
- MAX_OUTSTANDING, 4, maximum in-flight operations per APU; the APU is saturated at this count (>=1).
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived, do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- core_req_i  in  NB_CORES  per-core FPU request
- core_gnt_o  out  NB_CORES  per-core grant
- core_routing_addr_o  out  NB_CORES x $clog2(NB_APUS)  per-core APU index for this cycle
- core_alloc_valid_o  out  NB_CORES  routing address is meaningful (core requested and an APU was assigned)
- apu_req_o  out  NB_APUS  request to each APU
- apu_gnt_i  in  NB_APUS  APU accepts request
- apu_rvalid_i  in  NB_APUS  APU retires one operation (result valid)
- apu_status_o  out  NB_APUS  1 = APU saturated (count == MAX_OUTSTANDING)

Behaviour:
- Reset (async, rst_n=0):
  - all outstanding counters = 0;
  - round-robin pointer rr_q = 0;
  - apu_status_o = 0;
  - all combinational outputs evaluate to 0, because core_req_i is ignored while in reset.
- Allocation (combinational, same cycle, zero latency):
  - Visit cores in rotated order rr_q, rr_q+1, ... modulo NB_CORES.
  - Each requesting core takes the eligible APU with the smallest outstanding count; ties go to the lowest index.
  - Eligible means not saturated and not already taken by an earlier-visited core this cycle.
  - Once no eligible APU remains, the remaining requesters get core_alloc_valid_o=0, core_gnt_o=0 and core_routing_addr_o=0.
- Handshake:
  - apu_req_o[a]=1 iff some core is assigned APU a.
  - That core's core_gnt_o = apu_gnt_i[a], a pass-through with no registering.
  - A request is accepted when apu_req_o[a] & apu_gnt_i[a].
  - A core whose request is not granted must hold its request; it may be re-allocated to a different APU next cycle.
- Counters, per APU, registered:
  - accept only: +1.
  - rvalid only: -1.
  - accept and rvalid in the same cycle: unchanged.
  - rvalid while count==0: protocol error; count saturates at 0 (simulation assertion fires).
  - accept while count==MAX_OUTSTANDING cannot occur, because saturated APUs are never requested.
- apu_status_o: registered from the next-state counter compare, so it equals (count_q == MAX_OUTSTANDING).
- Round-robin pointer:
  - When at least one accept occurs, rr_q <= (index of the last accepted core in visit order) + 1, modulo NB_CORES.
  - With no accept, rr_q holds.
  - This prevents starvation of low-priority cores.
- Degenerate NB_APUS==1:
  - routing address width is forced to 1 and all routing addresses are 0;
  - single eligibility check; allocation reduces to round-robin arbitration.
- Degenerate NB_CORES==1: rr_q is constant 0.
- Mid-operation reset: counters clear immediately; in-flight results arriving after reset are the integrator's responsibility (the assertion is masked for 2 cycles after reset release).

Decomposition:
- Package fpu_alloc_pkg:
  - function log2_min1(n), returning max(1,$clog2(n));
  - typedef apu_idx_t, cnt_t;
  - localparam-style helpers for rotated index arithmetic.
- Sub-module fpu_apu_outstanding_cnt, one instance per APU:
  - inc/dec/saturate counter;
  - outputs count and saturated flag.
- Allocation loop and rr pointer stay in the top level.

Test Plan:
- Reset then all 8 cores request, apu_gnt_i=4'hF, no rvalid -> cycle 1:
  - cores 0-3 granted to APUs 0,1,2,3 (counts 0, ties to lowest index);
  - cores 4-7 not granted;
  - rr_q becomes 4.
- Cycle 2, same stimulus -> cores 4-7 granted to APUs 0-3; all counts = 2.
- Single core 2 requesting, counts {3,1,2,1} -> routing addr 1 (least loaded, lowest index on tie); count[1] -> 2.
- Saturation, MAX_OUTSTANDING=4:
  - hold APU0 at 4 -> apu_status_o=4'b0001 and APU0 never requested;
  - one apu_rvalid_i[0] -> count 3, status clears next cycle.
- Simultaneous accept and rvalid on APU2 at count 2 -> count stays 2. Also, apu_gnt_i[1]=0 while core assigned APU1 -> that core's gnt=0, count[1] unchanged, and the core is re-allocated next cycle.
- Assert rst_n=0 asynchronously mid-burst with counts {4,4,3,2} -> counts=0, status=0 and rr_q=0 before the next clock edge; allocation restarts from core 0.

Source files
------------

// File: rtl/fpu_alloc_pkg.sv
// Shared types and index helpers for the FPU/APU allocator slice.
// Latency: n/a (package only).
// Backpressure: n/a.
package fpu_alloc_pkg;

  localparam int DEF_NB_CORES        = 8;
  localparam int DEF_NB_APUS         = 4;
  localparam int DEF_MAX_OUTSTANDING = 4;

  // Index width that never collapses to zero bits (one APU still needs a 1-bit address).
  function automatic int log2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // k-th core visited when the scan starts at base.
  function automatic int rot_idx(input int base, input int k, input int n);
    return (base + k) % n;
  endfunction

  // Successor of idx in a ring of n entries.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

  // Sized for the default configuration; parameterised blocks derive their own widths.
  typedef logic [log2_min1(DEF_NB_APUS)-1:0]         apu_idx_t;
  typedef logic [$clog2(DEF_MAX_OUTSTANDING+1)-1:0]  cnt_t;

endpackage

// File: rtl/fpu_apu_outstanding_cnt.sv
// Per-APU outstanding-operation counter with saturated flag.
// Latency: count and flag update one cycle after the accept/retire event.
// Backpressure: none; the allocator stops requesting an APU while its flag is set.
module fpu_apu_outstanding_cnt
  import fpu_alloc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 sat_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic [1:0]           guard_q, guard_d;

  // Next count: accept and retire together cancel; retire at zero is clamped.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end
    sat_d   = (cnt_d == CNT_MAX);
    guard_d = guard_q[1] ? guard_q : guard_q + 2'd1;
  end

  // Counter, saturated flag and post-reset guard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      guard_q <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      guard_q <= guard_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

  // Results still in flight across a reset may retire into an empty counter,
  // so the underflow check waits two cycles after reset release.
  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    (guard_q[1] && dec_i && !inc_i) |-> (cnt_q != '0)
  );

endmodule

// File: rtl/fpu_apu_allocator.sv
// Shares NB_APUS FPUs among NB_CORES cores: each requester gets a distinct least-loaded free APU.
// Latency: allocation, routing and grant are combinational (zero cycles); load counters update next cycle.
// Backpressure: grant is passed straight from the APU; an ungranted core holds its request and is re-allocated.
module fpu_apu_allocator
  import fpu_alloc_pkg::*;
#(
  parameter int NB_CORES        = 8,
  parameter int NB_APUS         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NB_CORES-1:0]                    core_req_i,
  output logic [NB_CORES-1:0]                    core_gnt_o,
  output logic [NB_CORES*log2_min1(NB_APUS)-1:0] core_routing_addr_o,
  output logic [NB_CORES-1:0]                    core_alloc_valid_o,
  output logic [NB_APUS-1:0]                     apu_req_o,
  input  logic [NB_APUS-1:0]                     apu_gnt_i,
  input  logic [NB_APUS-1:0]                     apu_rvalid_i,
  output logic [NB_APUS-1:0]                     apu_status_o
);

  localparam int IDX_W = log2_min1(NB_APUS);
  localparam int RR_W  = log2_min1(NB_CORES);

  logic [NB_CORES-1:0]  req_eff;
  logic [CNT_WIDTH-1:0] apu_cnt [NB_APUS];
  logic [NB_APUS-1:0]   apu_sat;
  logic [NB_APUS-1:0]   apu_taken;
  logic [NB_APUS-1:0]   apu_inc;
  logic [RR_W-1:0]      rr_q, rr_d;
  logic                 any_acc;
  int                   last_acc;
  int                   visit_c;
  int                   best_a;
  logic                 best_found;

  // Requests are ignored while reset is held so every combinational output reads zero.
  assign req_eff = core_req_i & {NB_CORES{rst_n}};

  for (genvar a = 0; a < NB_APUS; a++) begin : g_cnt
    fpu_apu_outstanding_cnt #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_WIDTH       (CNT_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (apu_inc[a]),
      .dec_i (apu_rvalid_i[a]),
      .cnt_o (apu_cnt[a]),
      .sat_o (apu_sat[a])
    );
  end

  // Scan cores from the round-robin pointer; each requester claims the least-loaded free APU.
  always_comb begin
    apu_taken           = '0;
    core_gnt_o          = '0;
    core_alloc_valid_o  = '0;
    core_routing_addr_o = '0;
    any_acc             = 1'b0;
    last_acc            = 0;
    visit_c             = 0;
    best_a              = 0;
    best_found          = 1'b0;
    for (int k = 0; k < NB_CORES; k++) begin
      visit_c    = rot_idx(int'(rr_q), k, NB_CORES);
      best_found = 1'b0;
      best_a     = 0;
      // Strict less-than keeps the lowest index on equal load.
      for (int a = 0; a < NB_APUS; a++) begin
        if (!apu_sat[a] && !apu_taken[a] &&
            (!best_found || (apu_cnt[a] < apu_cnt[best_a]))) begin
          best_found = 1'b1;
          best_a     = a;
        end
      end
      if (req_eff[visit_c] && best_found) begin
        apu_taken[best_a]                             = 1'b1;
        core_alloc_valid_o[visit_c]                   = 1'b1;
        core_routing_addr_o[visit_c*IDX_W +: IDX_W]   = IDX_W'(best_a);
        core_gnt_o[visit_c]                           = apu_gnt_i[best_a];
        if (apu_gnt_i[best_a]) begin
          any_acc  = 1'b1;
          last_acc = visit_c;
        end
      end
    end
  end

  assign apu_req_o    = apu_taken;
  assign apu_inc      = apu_taken & apu_gnt_i;
  assign apu_status_o = apu_sat;

  // Next scan starts just past the last core that was accepted this cycle.
  always_comb begin
    rr_d = rr_q;
    if (any_acc) begin
      rr_d = RR_W'(next_idx(last_acc, NB_CORES));
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: tb/tb_fpu_apu_allocator.sv
// Self-checking bench for fpu_apu_allocator: directed vector table, reset sequences,
// and randomized traffic compared against a sorted-free-list reference model.
module tb_fpu_apu_allocator;
  import fpu_alloc_pkg::*;

  localparam int NC   = 8;
  localparam int NA   = 4;
  localparam int MAXO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] core_req_i;
  logic [NC-1:0] core_gnt_o;
  logic [2*NC-1:0] core_routing_addr_o;
  logic [NC-1:0] core_alloc_valid_o;
  logic [NA-1:0] apu_req_o;
  logic [NA-1:0] apu_gnt_i;
  logic [NA-1:0] apu_rvalid_i;
  logic [NA-1:0] apu_status_o;

  fpu_apu_allocator #(
    .NB_CORES        (NC),
    .NB_APUS         (NA),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .core_req_i          (core_req_i),
    .core_gnt_o          (core_gnt_o),
    .core_routing_addr_o (core_routing_addr_o),
    .core_alloc_valid_o  (core_alloc_valid_o),
    .apu_req_o           (apu_req_o),
    .apu_gnt_i           (apu_gnt_i),
    .apu_rvalid_i        (apu_rvalid_i),
    .apu_status_o        (apu_status_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [7:0]  e_gnt;
    logic [7:0]  e_valid;
    logic [15:0] e_addr;
    logic [3:0]  e_apureq;
    logic [3:0]  e_status;
  } vec_t;

  vec_t tbl [10];
  vec_t v;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: per-APU load and scan start.
  int          m_cnt [NA];
  int          m_rr;
  logic [7:0]  m_gnt, m_valid;
  logic [15:0] m_addr;
  logic [3:0]  m_apureq, m_acc, m_status;
  int          m_last;
  bit          m_any;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) m_cnt[i] = 0;
    m_rr = 0;
  endtask

  // Free APUs ordered by (load, index); the j-th requester in scan order gets the j-th entry.
  task automatic model_eval(input logic [7:0] req, input logic [3:0] gnt);
    int keys[$];
    int j;
    int c;
    int a;
    m_gnt = '0; m_valid = '0; m_addr = '0; m_apureq = '0; m_acc = '0;
    m_any = 0; m_last = 0; j = 0;
    for (int i = 0; i < NA; i++) begin
      m_status[i] = (m_cnt[i] == MAXO);
      if (m_cnt[i] < MAXO) keys.push_back(m_cnt[i] * 16 + i);
    end
    keys.sort();
    for (int k = 0; k < NC; k++) begin
      c = (m_rr + k) % NC;
      if (req[c] && (j < keys.size())) begin
        a = keys[j] % 16;
        j++;
        m_valid[c]      = 1'b1;
        m_addr[2*c +: 2] = 2'(a);
        m_apureq[a]     = 1'b1;
        m_gnt[c]        = gnt[a];
        m_acc[a]        = gnt[a];
        if (gnt[a]) begin
          m_any  = 1;
          m_last = c;
        end
      end
    end
  endtask

  task automatic model_commit(input logic [3:0] rv);
    for (int i = 0; i < NA; i++) begin
      m_cnt[i] = m_cnt[i] + int'(m_acc[i]) - int'(rv[i]);
      if (m_cnt[i] < 0) m_cnt[i] = 0;
    end
    if (m_any) m_rr = (m_last + 1) % NC;
  endtask

  task automatic model_checks(input string tag);
    chk({tag, ".gnt"},    32'(core_gnt_o),          32'(m_gnt));
    chk({tag, ".valid"},  32'(core_alloc_valid_o),  32'(m_valid));
    chk({tag, ".addr"},   32'(core_routing_addr_o), 32'(m_addr));
    chk({tag, ".apureq"}, 32'(apu_req_o),           32'(m_apureq));
    chk({tag, ".status"}, 32'(apu_status_o),        32'(m_status));
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, ".gnt"},    32'(core_gnt_o),          32'h0);
    chk({tag, ".valid"},  32'(core_alloc_valid_o),  32'h0);
    chk({tag, ".addr"},   32'(core_routing_addr_o), 32'h0);
    chk({tag, ".apureq"}, 32'(apu_req_o),           32'h0);
    chk({tag, ".status"}, 32'(apu_status_o),        32'h0);
  endtask

  // One cycle: drive after the falling edge, check before the rising edge, advance the model.
  task automatic step(input vec_t s, input bit use_tbl, input string tag);
    core_req_i   = s.req;
    apu_gnt_i    = s.gnt;
    apu_rvalid_i = s.rv;
    #1;
    model_eval(s.req, s.gnt);
    model_checks(tag);
    if (use_tbl) begin
      chk({tag, ".t_gnt"},    32'(core_gnt_o),          32'(s.e_gnt));
      chk({tag, ".t_valid"},  32'(core_alloc_valid_o),  32'(s.e_valid));
      chk({tag, ".t_addr"},   32'(core_routing_addr_o), 32'(s.e_addr));
      chk({tag, ".t_apureq"}, 32'(apu_req_o),           32'(s.e_apureq));
      chk({tag, ".t_status"}, 32'(apu_status_o),        32'(s.e_status));
    end
    @(posedge clk);
    model_commit(s.rv);
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            req    gnt   rv    e_gnt  e_valid e_addr    e_apureq e_status
    tbl[0] = '{8'hFF, 4'hF, 4'h0, 8'h0F, 8'h0F, 16'h00E4, 4'hF, 4'h0}; // cores 0-3 -> APUs 0-3
    tbl[1] = '{8'hFF, 4'hF, 4'h0, 8'hF0, 8'hF0, 16'hE400, 4'hF, 4'h0}; // cores 4-7 -> APUs 0-3
    tbl[2] = '{8'h01, 4'hF, 4'hA, 8'h01, 8'h01, 16'h0000, 4'h1, 4'h0}; // build loads {3,1,2,1}
    tbl[3] = '{8'h04, 4'hF, 4'h0, 8'h04, 8'h04, 16'h0010, 4'h2, 4'h0}; // core2 -> APU1 (tie low)
    tbl[4] = '{8'h78, 4'h1, 4'h0, 8'h40, 8'h78, 16'h09C0, 4'hF, 4'h0}; // only APU0 grants -> 4
    tbl[5] = '{8'hFF, 4'hF, 4'h0, 8'h83, 8'h83, 16'hC009, 4'hE, 4'h1}; // APU0 saturated, skipped
    tbl[6] = '{8'h00, 4'hF, 4'h5, 8'h00, 8'h00, 16'h0000, 4'h0, 4'h1}; // retire on APU0 and APU2
    tbl[7] = '{8'h3C, 4'hD, 4'h4, 8'h1C, 8'h3C, 16'h04E0, 4'hF, 4'h0}; // APU1 refuses; APU2 acc+ret
    tbl[8] = '{8'h20, 4'hF, 4'h0, 8'h20, 8'h20, 16'h0800, 4'h4, 4'h1}; // core5 moves to APU2
    tbl[9] = '{8'h40, 4'hF, 4'h8, 8'h40, 8'h40, 16'h1000, 4'h2, 4'h1}; // loads -> {4,4,3,2}

    // Reset: outputs must be zero even with requests present.
    rst_n = 1'b0; core_req_i = 8'hFF; apu_gnt_i = 4'hF; apu_rvalid_i = 4'h0;
    model_reset();
    #3;
    zero_checks("reset");
    @(negedge clk);
    core_req_i = 8'h00;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i], 1'b1, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a burst, then allocation restarts from core 0.
    core_req_i = 8'hFF; apu_gnt_i = 4'hF; apu_rvalid_i = 4'h0;
    #1;
    model_eval(8'hFF, 4'hF);
    model_checks("preburst");
    #2;
    rst_n = 1'b0;
    #1;
    zero_checks("midreset");
    @(posedge clk);
    @(negedge clk);
    core_req_i = 8'h00;
    rst_n = 1'b1;
    model_reset();
    step(tbl[0], 1'b1, "restart");

    // Randomized traffic; retires are only issued to APUs the model believes are busy.
    for (int n = 0; n < 400; n++) begin
      v.req = 8'($urandom);
      v.gnt = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      v.rv  = '0;
      for (int i = 0; i < NA; i++) begin
        if ((m_cnt[i] > 0) && ($urandom_range(0, 1) == 0)) v.rv[i] = 1'b1;
      end
      step(v, 1'b0, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
